pwm_duty_meter: RTL and testbench

Measures high time and period of a single PWM channel, e.g. one bit of the 4-channel PWM generator output, in clk cycles. Synchronises the input, detects edges, counts, and publishes a (high_cnt, period_cnt) pair with a one-cycle valid strobe once per PWM period. Flags a stuck-high or stuck-low input when no edge arrives within a timeout. Used as the loopback checker/monitor downstream of the PWM generator.

---
 rtl/pwm_duty_meter.sv | 178 +++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// PWM duty/period meter: synchronises one PWM input, measures high time and period in clk
// cycles, publishes one (high_cnt, period_cnt) pair per period and flags a stuck input.
module pwm_duty_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             clear,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             stuck_high,
    output logic             stuck_low
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    localparam logic [CNT_W-1:0] CntMax      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TimeoutMax  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   edge_seen;
    logic                   timeout;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             sh_q, sh_d;
    logic             sl_q, sl_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Edges are registered so that s_d_q is the level aligned with rise_q/fall_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d_q  <= s;
            rise_q <= s & ~s_d_q;
            fall_q <= ~s & s_d_q;
        end
    end

    assign edge_seen = rise_q | fall_q;
    assign timeout   = (tcnt_q == TimeoutLast);

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        high_d   = high_q;
        period_d = period_q;
        sh_d     = sh_q;
        sl_d     = sl_q;

        if (rise_q) begin
            pcnt_d = CntOne;
        end else if (pcnt_q != CntMax) begin
            pcnt_d = pcnt_q + 1'b1;
        end else begin
            pcnt_d = pcnt_q;
        end

        if (rise_q) begin
            hcnt_d = CntOne;
        end else if (s_d_q && (hcnt_q != CntMax)) begin
            hcnt_d = hcnt_q + 1'b1;
        end else begin
            hcnt_d = hcnt_q;
        end

        // Cycles since the last edge of either polarity; parks at TIMEOUT.
        if (edge_seen) begin
            tcnt_d = '0;
        end else if (tcnt_q != TimeoutMax) begin
            tcnt_d = tcnt_q + 1'b1;
        end else begin
            tcnt_d = tcnt_q;
        end

        if (edge_seen) begin
            sh_d = 1'b0;
            sl_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (rise_q) begin
                    state_d = StHigh;
                end else if (timeout && !fall_q) begin
                    sh_d = s_d_q;
                    sl_d = ~s_d_q;
                end
            end
            StHigh: begin
                if (fall_q) begin
                    state_d = StLow;
                end else if (timeout) begin
                    sh_d    = 1'b1;
                    sl_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            StLow: begin
                if (rise_q) begin
                    high_d   = hcnt_q;
                    period_d = pcnt_q;
                    valid_d  = 1'b1;
                    state_d  = StHigh;
                end else if (timeout) begin
                    sl_d    = 1'b1;
                    sh_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            state_d  = StIdle;
            valid_d  = 1'b0;
            high_d   = '0;
            period_d = '0;
            sh_d     = 1'b0;
            sl_d     = 1'b0;
            pcnt_d   = '0;
            hcnt_d   = '0;
            tcnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            tcnt_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            sh_q     <= 1'b0;
            sl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            tcnt_q   <= tcnt_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            sh_q     <= sh_d;
            sl_q     <= sl_d;
        end
    end

    assign meas_valid = valid_q;
    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign stuck_high = sh_q;
    assign stuck_low  = sl_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: duty patterns, stuck detection, clear and async reset.
module tb_pwm_duty_meter;

    logic        clk;
    logic        rst;
    logic        pwm_in;
    logic        clear;
    logic        meas_valid;
    logic [15:0] high_cnt;
    logic [15:0] period_cnt;
    logic        stuck_high;
    logic        stuck_low;

    int tests_run;
    int tests_failed;
    int cyc;
    int rise_cyc;
    logic prev_pwm;

    // Strobe log: values and the cycle each strobe was seen.
    logic [15:0] q_h[$];
    logic [15:0] q_p[$];
    int          q_c[$];

    pwm_duty_meter #(
        .CNT_W      (16),
        .SYNC_STAGES(2),
        .TIMEOUT    (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .clear     (clear),
        .meas_valid(meas_valid),
        .high_cnt  (high_cnt),
        .period_cnt(period_cnt),
        .stuck_high(stuck_high),
        .stuck_low (stuck_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input logic v);
        pwm_in = v;
        @(posedge clk);
        #1;
        cyc++;
        if (v && !prev_pwm) rise_cyc = cyc;
        prev_pwm = v;
        if (meas_valid) begin
            q_h.push_back(high_cnt);
            q_p.push_back(period_cnt);
            q_c.push_back(cyc);
        end
    endtask

    task automatic periods(input int h, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) tick(i < h);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        clear = 1'b0;
        repeat (3) tick(1'b0);
        rst = 1'b0;
        q_h.delete();
        q_p.delete();
        q_c.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (meas_valid !== 1'b0) begin
            $display("FAIL reset_valid: got %0b expected 0", meas_valid); tests_failed++;
        end
        tests_run++;
        if (high_cnt !== 16'd0) begin
            $display("FAIL reset_high: got %0d expected 0", high_cnt); tests_failed++;
        end
        tests_run++;
        if (period_cnt !== 16'd0) begin
            $display("FAIL reset_period: got %0d expected 0", period_cnt); tests_failed++;
        end
        tests_run++;
        if ({stuck_high, stuck_low} !== 2'b00) begin
            $display("FAIL reset_stuck: got %b expected 00", {stuck_high, stuck_low});
            tests_failed++;
        end
    endtask

    task automatic test_duty20();
        int t0;
        do_reset();
        t0 = cyc;
        periods(20, 100, 6);
        tests_run++;
        if (q_h.size() != 5) begin
            $display("FAIL d20_count: got %0d expected 5", q_h.size()); tests_failed++;
        end
        for (int i = 0; i < q_h.size(); i++) begin
            tests_run++;
            if (q_h[i] !== 16'd20 || q_p[i] !== 16'd100 || q_c[i] != t0 + 104 + 100 * i) begin
                $display("FAIL d20_meas%0d: got %0d/%0d @%0d expected 20/100 @%0d",
                         i, q_h[i], q_p[i], q_c[i] - t0, 104 + 100 * i);
                tests_failed++;
            end
        end
        tests_run++;
        if ({stuck_high, stuck_low} !== 2'b00) begin
            $display("FAIL d20_stuck: got %b expected 00", {stuck_high, stuck_low});
            tests_failed++;
        end
    endtask

    task automatic test_duty_switch();
        logic [15:0] exp_h;
        do_reset();
        periods(80, 100, 3);
        periods(40, 100, 3);
        repeat (5) tick(1'b1);
        tests_run++;
        if (q_h.size() != 6) begin
            $display("FAIL sw_count: got %0d expected 6", q_h.size()); tests_failed++;
        end
        for (int i = 0; i < q_h.size(); i++) begin
            exp_h = (i < 3) ? 16'd80 : 16'd40;
            tests_run++;
            if (q_h[i] !== exp_h || q_p[i] !== 16'd100) begin
                $display("FAIL sw_meas%0d: got %0d/%0d expected %0d/100",
                         i, q_h[i], q_p[i], exp_h);
                tests_failed++;
            end
        end
    endtask

    // Continues from test_duty_switch with the input left high.
    task automatic test_stuck_high();
        int c0;
        int n0;
        c0 = rise_cyc;
        n0 = q_h.size();
        while (cyc < c0 + 1100) begin
            tick(1'b1);
            if (cyc == c0 + 995) begin
                tests_run++;
                if (stuck_high !== 1'b0) begin
                    $display("FAIL sh_early: got %0b expected 0", stuck_high); tests_failed++;
                end
            end
            if (cyc == c0 + 1010) begin
                tests_run++;
                if (stuck_high !== 1'b1 || stuck_low !== 1'b0) begin
                    $display("FAIL sh_set: got sh=%0b sl=%0b expected sh=1 sl=0",
                             stuck_high, stuck_low);
                    tests_failed++;
                end
                tests_run++;
                if (high_cnt !== 16'd40 || period_cnt !== 16'd100) begin
                    $display("FAIL sh_hold: got %0d/%0d expected 40/100", high_cnt, period_cnt);
                    tests_failed++;
                end
            end
        end
        tests_run++;
        if (q_h.size() != n0) begin
            $display("FAIL sh_nostrobe: got %0d expected %0d", q_h.size(), n0); tests_failed++;
        end
        repeat (10) tick(1'b0);
        tests_run++;
        if ({stuck_high, stuck_low} !== 2'b00) begin
            $display("FAIL sh_clear: got %b expected 00", {stuck_high, stuck_low});
            tests_failed++;
        end
        n0 = q_h.size();
        periods(30, 100, 3);
        repeat (5) tick(1'b1);
        tests_run++;
        if (q_h.size() != n0 + 3) begin
            $display("FAIL sh_recover_count: got %0d expected %0d", q_h.size(), n0 + 3);
            tests_failed++;
        end
        for (int i = n0; i < q_h.size(); i++) begin
            tests_run++;
            if (q_h[i] !== 16'd30 || q_p[i] !== 16'd100) begin
                $display("FAIL sh_recover%0d: got %0d/%0d expected 30/100", i, q_h[i], q_p[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_stuck_low();
        int r0;
        do_reset();
        r0 = cyc;
        while (cyc < r0 + 1100) begin
            tick(1'b0);
            if (cyc == r0 + 990) begin
                tests_run++;
                if (stuck_low !== 1'b0) begin
                    $display("FAIL sl_early: got %0b expected 0", stuck_low); tests_failed++;
                end
            end
            if (cyc == r0 + 1010) begin
                tests_run++;
                if (stuck_low !== 1'b1 || stuck_high !== 1'b0) begin
                    $display("FAIL sl_set: got sl=%0b sh=%0b expected sl=1 sh=0",
                             stuck_low, stuck_high);
                    tests_failed++;
                end
            end
        end
        tests_run++;
        if (q_h.size() != 0 || high_cnt !== 16'd0 || period_cnt !== 16'd0) begin
            $display("FAIL sl_quiet: got %0d strobes %0d/%0d expected 0 strobes 0/0",
                     q_h.size(), high_cnt, period_cnt);
            tests_failed++;
        end
    endtask

    task automatic test_clear();
        int n0;
        int c5;
        do_reset();
        periods(20, 100, 2);
        repeat (10) tick(1'b1);
        clear = 1'b1;
        tick(1'b1);
        clear = 1'b0;
        tests_run++;
        if (high_cnt !== 16'd0 || period_cnt !== 16'd0 || meas_valid !== 1'b0) begin
            $display("FAIL clr_outputs: got %0d/%0d v=%0b expected 0/0 v=0",
                     high_cnt, period_cnt, meas_valid);
            tests_failed++;
        end
        n0 = q_h.size();
        repeat (9) tick(1'b1);
        repeat (80) tick(1'b0);
        periods(20, 100, 1);
        c5 = cyc + 1;
        periods(20, 100, 1);
        repeat (5) tick(1'b1);
        tests_run++;
        if (q_h.size() != n0 + 2) begin
            $display("FAIL clr_count: got %0d expected %0d", q_h.size(), n0 + 2);
            tests_failed++;
        end else begin
            tests_run++;
            if (q_c[n0] != c5 + 3) begin
                $display("FAIL clr_first: got cycle %0d expected %0d", q_c[n0], c5 + 3);
                tests_failed++;
            end
        end
        for (int i = n0; i < q_h.size(); i++) begin
            tests_run++;
            if (q_h[i] !== 16'd20 || q_p[i] !== 16'd100) begin
                $display("FAIL clr_meas%0d: got %0d/%0d expected 20/100", i, q_h[i], q_p[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        periods(20, 100, 2);
        repeat (20) tick(1'b1);
        repeat (10) tick(1'b0);
        tests_run++;
        if (high_cnt !== 16'd20) begin
            $display("FAIL ar_before: got %0d expected 20", high_cnt); tests_failed++;
        end
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (high_cnt !== 16'd0 || period_cnt !== 16'd0 || meas_valid !== 1'b0) begin
            $display("FAIL ar_immediate: got %0d/%0d v=%0b expected 0/0 v=0",
                     high_cnt, period_cnt, meas_valid);
            tests_failed++;
        end
        repeat (2) tick(1'b0);
        rst = 1'b0;
        q_h.delete();
        q_p.delete();
        q_c.delete();
        repeat (5) tick(1'b0);
        periods(20, 100, 1);
        repeat (5) tick(1'b1);
        tests_run++;
        if (q_h.size() != 1) begin
            $display("FAIL ar_count: got %0d expected 1", q_h.size()); tests_failed++;
        end else begin
            tests_run++;
            if (q_c[0] != rise_cyc + 3 || q_h[0] !== 16'd20 || q_p[0] !== 16'd100) begin
                $display("FAIL ar_latency: got %0d/%0d @+%0d expected 20/100 @+3",
                         q_h[0], q_p[0], q_c[0] - rise_cyc);
                tests_failed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_reset();
        t0 = cyc;
        periods(1, 2, 5);
        repeat (5) tick(1'b1);
        tests_run++;
        if (q_h.size() != 5) begin
            $display("FAIL b2b_count: got %0d expected 5", q_h.size()); tests_failed++;
        end
        for (int i = 0; i < q_h.size(); i++) begin
            tests_run++;
            if (q_h[i] !== 16'd1 || q_p[i] !== 16'd2 || q_c[i] != t0 + 6 + 2 * i) begin
                $display("FAIL b2b_meas%0d: got %0d/%0d @%0d expected 1/2 @%0d",
                         i, q_h[i], q_p[i], q_c[i] - t0, 6 + 2 * i);
                tests_failed++;
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rise_cyc     = 0;
        prev_pwm     = 1'b0;
        rst          = 1'b1;
        clear        = 1'b0;
        pwm_in       = 1'b0;
        test_reset();
        test_duty20();
        test_duty_switch();
        test_stuck_high();
        test_stuck_low();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
